// File: rtl/ckbuf_gate_ctrl.sv
// ckbuf_gate_ctrl -- clock-buffer gating controller.
//   Enables a clock-buffer core while any requester (or force_on_i) wants the
//   clock. It warms the buffer up for WARM_CYC cycles before the first grant
//   and keeps it on for HOLD_CYC idle cycles before turning it off again.
//   Optional stats counter: define CKBUF_GATE_CTRL_STATS_EN.
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      async active-low reset
//   req_i        [NREQ] per-requester level request
//   force_on_i   keep the buffer enabled regardless of requests
//   stats_clr_i  (stats build only) synchronous clear of en_cycles_o
//   en_cycles_o  (stats build only) saturating count of enabled cycles
//   ckbuf_en_o   registered buffer enable
//   ack_o        [NREQ] registered per-requester grant
//   state_o      FSM state: 0=IDLE 1=WARMUP 2=ON 3=HOLD

// Per-requester grant flop: grant while requesting and the FSM heads to ON.
module ckbuf_ack_cell (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_i,
  input  logic on_d_i,
  output logic ack_o
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) ack_o <= 1'b0;
    else          ack_o <= req_i & on_d_i;
endmodule

module ckbuf_gate_ctrl #(
  parameter int NREQ     = 4,
  parameter int WARM_CYC = 4,
  parameter int HOLD_CYC = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            force_on_i,
`ifdef CKBUF_GATE_CTRL_STATS_EN
  input  logic            stats_clr_i,
  output logic [15:0]     en_cycles_o,
`endif
  output logic            ckbuf_en_o,
  output logic [NREQ-1:0] ack_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    ON     = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [7:0] WARM_LD = 8'(WARM_CYC - 1);
  // HOLD_CYC=0 bypasses HOLD entirely, so the load value is never used then.
  localparam logic [7:0] HOLD_LD = (HOLD_CYC == 0) ? 8'd0 : 8'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q;
  logic       wake;

  assign wake = (|req_i) | force_on_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:
        if (wake) begin
          state_d = WARMUP;
          cnt_d   = WARM_LD;
        end
      // Warm-up always runs to completion; wake is only looked at once in ON.
      WARMUP:
        if (cnt_q == 8'd0) state_d = ON;
        else               cnt_d   = cnt_q - 8'd1;
      ON:
        if (!wake) begin
          if (HOLD_CYC == 0) state_d = IDLE;
          else begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      // A returning request wins over counter expiry: back to ON, no warm-up.
      HOLD:
        if (wake)                state_d = ON;
        else if (cnt_q == 8'd0)  state_d = IDLE;
        else                     cnt_d   = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != IDLE);
    end

  for (genvar k = 0; k < NREQ; k++) begin : g_ack
    ckbuf_ack_cell u_ack (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .req_i  (req_i[k]),
      .on_d_i (state_d == ON),
      .ack_o  (ack_o[k])
    );
  end

  assign ckbuf_en_o = en_q;
  assign state_o    = state_q;

`ifdef CKBUF_GATE_CTRL_STATS_EN
  logic [15:0] en_cycles_q;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)                        en_cycles_q <= 16'd0;
    else if (stats_clr_i)                en_cycles_q <= 16'd0;
    else if (en_q && en_cycles_q != 16'hFFFF) en_cycles_q <= en_cycles_q + 16'd1;

  assign en_cycles_o = en_cycles_q;
`endif

endmodule

// File: tb/tb_ckbuf_gate_ctrl.sv
module tb_ckbuf_gate_ctrl;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            force_on;
  logic            en0, en1;
  logic [NREQ-1:0] ack0, ack1;
  logic [1:0]      st0, st1;
`ifdef CKBUF_GATE_CTRL_STATS_EN
  logic            clr0, clr1;
  logic [15:0]     ecyc0, ecyc1;
`endif

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  ckbuf_gate_ctrl #(.NREQ(NREQ), .WARM_CYC(4), .HOLD_CYC(8)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .force_on_i(force_on),
`ifdef CKBUF_GATE_CTRL_STATS_EN
    .stats_clr_i(clr0), .en_cycles_o(ecyc0),
`endif
    .ckbuf_en_o(en0), .ack_o(ack0), .state_o(st0)
  );

  ckbuf_gate_ctrl #(.NREQ(NREQ), .WARM_CYC(4), .HOLD_CYC(0)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .force_on_i(force_on),
`ifdef CKBUF_GATE_CTRL_STATS_EN
    .stats_clr_i(clr1), .en_cycles_o(ecyc1),
`endif
    .ckbuf_en_o(en1), .ack_o(ack1), .state_o(st1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; force_on = 1'b0;
`ifdef CKBUF_GATE_CTRL_STATS_EN
    clr0 = 1'b0; clr1 = 1'b0;
`endif
    #12;
    chk("rst_en", en0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_st", st0, 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_noawake", st0, 0);

    // wake-up: req at cycle 0, second requester joins mid warm-up
    req = 4'b0001;
    tick(1);
    chk("c1_en", en0, 1);
    chk("c1_st", st0, 1);
    chk("c1_ack", ack0, 0);
    tick(1);
    req = 4'b0011;
    tick(2);
    chk("c4_st", st0, 1);
    chk("c4_ack", ack0, 0);
    tick(1);
    chk("c5_st", st0, 2);
    chk("c5_ack", ack0, 4'b0011);
    chk("c5_st_h0", st1, 2);
    req = 4'b0001;
    tick(1);
    chk("c6_ack", ack0, 4'b0001);
    req = 4'b0000;
    tick(1);
    chk("t1_ack", ack0, 0);
    chk("t1_st", st0, 3);
    chk("t1_en", en0, 1);
    chk("h0_st", st1, 0);
    chk("h0_en", en1, 0);
    tick(7);
    chk("t8_st", st0, 3);
    tick(1);
    chk("t9_st", st0, 0);
    chk("t9_en", en0, 0);

    // re-wake out of HOLD with cnt=3
    req = 4'b0001;
    tick(5);
    chk("rw_on", st0, 2);
    req = 4'b0000;
    tick(5);
    chk("rw_hold", st0, 3);
    req = 4'b0100;
    tick(1);
    chk("rw_st", st0, 2);
    chk("rw_ack", ack0, 4'b0100);
    chk("rw_en", en0, 1);

    // wake coincides with HOLD counter expiry
    req = 4'b0000;
    tick(8);
    chk("exp_hold", st0, 3);
    req = 4'b0001;
    tick(1);
    chk("exp_st", st0, 2);
    chk("exp_ack", ack0, 4'b0001);
    req = 4'b0000;
    tick(9);
    chk("exp_idle", st0, 0);

    // warm-up is not aborted when wake drops
    req = 4'b0001;
    tick(1);
    req = 4'b0000;
    tick(3);
    chk("wa_c4", st0, 1);
    tick(1);
    chk("wa_c5", st0, 2);
    chk("wa_ack", ack0, 0);
    tick(1);
    chk("wa_c6", st0, 3);
    tick(8);
    chk("wa_idle", st0, 0);

    // force_on with no requests
    force_on = 1'b1;
    tick(5);
    chk("fo_on", st0, 2);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("fo_st", st0, 2);
      chk("fo_ack", ack0, 0);
    end

`ifdef CKBUF_GATE_CTRL_STATS_EN
    clr0 = 1'b1;
    tick(1);
    chk("st_clr0", ecyc0, 0);
    clr0 = 1'b0;
    tick(70000);
    chk("st_sat", ecyc0, 16'hFFFF);
    clr0 = 1'b1;
    tick(1);
    chk("st_clr1", ecyc0, 0);
    clr0 = 1'b0;
`endif

    // asynchronous reset mid-ON
    req = 4'b0001;
    tick(1);
    chk("pre_ack", ack0, 4'b0001);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_en", en0, 0);
    chk("ar_ack", ack0, 0);
    chk("ar_st", st0, 0);
    force_on = 1'b0;
    req = '0;
    #2 rst_n = 1'b1;
    tick(3);
    chk("post_idle", st0, 0);
    chk("post_en", en0, 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
